// File: rtl/hpdcache_flush_be.sv
// -----------------------------------------------------------------------------
// hpdcache_flush_be
//   Dirty-line flush controller. An accepted flush request allocates the lowest
//   free directory entry, queues one memory WRITE header (address, length, id)
//   and reads the victim line out of the data array ACCESS_WORDS words at a
//   time. The returned words and byte-dirty masks are packed into MEM_WORDS-wide
//   flits, which are queued towards memory with the dirty masks as byte enables.
//   A directory entry stays valid until the matching write ack arrives, and the
//   check port reports whether a line is still in flight.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   flush_empty_o / flush_full_o     directory occupancy
//   flush_check_*                    in-flight line lookup
//   flush_alloc_*                    flush request handshake (nline, one-hot way)
//   flush_data_read_*                data-array read strobe/address and response
//   flush_ack_*                      write-ack notification (combinational)
//   mem_req_write_*                  write header channel
//   mem_req_write_data_*             write data flit channel
//   mem_resp_write_*                 write ack channel (always ready)
// -----------------------------------------------------------------------------
module hpdcache_flush_be #(
    parameter int NLINE_W       = 26,
    parameter int SET_W         = 7,
    parameter int WAYS          = 4,
    parameter int CL_WORDS      = 8,
    parameter int ACCESS_WORDS  = 2,
    parameter int MEM_WORDS     = 4,
    parameter int FLUSH_ENTRIES = 4,
    parameter int FIFO_DEPTH    = 2,
    localparam int ID_W   = (FLUSH_ENTRIES > 1) ? $clog2(FLUSH_ENTRIES) : 1,
    localparam int WORD_W = $clog2(CL_WORDS),
    localparam int ADDR_W = NLINE_W + $clog2(CL_WORDS * 8)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    output logic                      flush_empty_o,
    output logic                      flush_full_o,
    input  logic [NLINE_W-1:0]        flush_check_nline_i,
    output logic                      flush_check_hit_o,
    input  logic                      flush_alloc_i,
    output logic                      flush_alloc_ready_o,
    input  logic [NLINE_W-1:0]        flush_alloc_nline_i,
    input  logic [WAYS-1:0]           flush_alloc_way_i,
    output logic                      flush_data_read_o,
    output logic [SET_W-1:0]          flush_data_read_set_o,
    output logic [WORD_W-1:0]         flush_data_read_word_o,
    output logic [WAYS-1:0]           flush_data_read_way_o,
    input  logic [64*ACCESS_WORDS-1:0] flush_data_read_data_i,
    input  logic [8*ACCESS_WORDS-1:0] flush_data_read_dirty_i,
    output logic                      flush_ack_o,
    output logic [NLINE_W-1:0]        flush_ack_nline_o,
    input  logic                      mem_req_write_ready_i,
    output logic                      mem_req_write_valid_o,
    output logic [ADDR_W-1:0]         mem_req_write_addr_o,
    output logic [7:0]                mem_req_write_len_o,
    output logic [ID_W-1:0]           mem_req_write_id_o,
    input  logic                      mem_req_write_data_ready_i,
    output logic                      mem_req_write_data_valid_o,
    output logic [64*MEM_WORDS-1:0]   mem_req_write_data_o,
    output logic [8*MEM_WORDS-1:0]    mem_req_write_be_o,
    output logic                      mem_req_write_last_o,
    input  logic                      mem_resp_write_valid_i,
    input  logic [ID_W-1:0]           mem_resp_write_id_i,
    output logic                      mem_resp_write_ready_o
);
    localparam int ACC_W   = 64 * ACCESS_WORDS;
    localparam int ACC_BE  = 8 * ACCESS_WORDS;
    localparam int FLIT_W  = 64 * MEM_WORDS;
    localparam int FLIT_BE = 8 * MEM_WORDS;
    localparam int OFF_W   = $clog2(CL_WORDS * 8);
    localparam int APF     = MEM_WORDS / ACCESS_WORDS;
    localparam int SLOT_W  = (APF > 1) ? $clog2(APF) : 1;
    localparam int FP_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FC_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(CL_WORDS - ACCESS_WORDS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(APF - 1);
    localparam logic [7:0]        LEN       = 8'(CL_WORDS / MEM_WORDS - 1);

    typedef enum logic {ST_IDLE, ST_READ} state_e;

    state_e                    state_q, state_d;
    logic [WORD_W-1:0]         word_q, word_d;
    logic [SET_W-1:0]          set_q, set_d;
    logic [WAYS-1:0]           way_q, way_d;
    logic [FLUSH_ENTRIES-1:0]  dir_vld_q, dir_vld_d;
    logic [NLINE_W-1:0]        dir_nline_q [FLUSH_ENTRIES];
    logic [ADDR_W-1:0]         meta_addr_q [2];
    logic [ID_W-1:0]           meta_id_q   [2];
    logic                      meta_wptr_q, meta_rptr_q;
    logic [1:0]                meta_cnt_q;
    logic [FLIT_W-1:0]         df_data_q [FIFO_DEPTH];
    logic [FLIT_BE-1:0]        df_be_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     df_last_q;
    logic [FP_W-1:0]           df_wptr_q, df_rptr_q;
    logic [FC_W-1:0]           df_cnt_q, inflight_q;
    logic                      rsp_vld_q, rsp_last_q;
    logic [SLOT_W-1:0]         acc_q;
    logic [FLIT_W-1:0]         flit_data_q, flit_data_n;
    logic [FLIT_BE-1:0]        flit_be_q, flit_be_n;

    logic                      free_found;
    logic [ID_W-1:0]           free_idx;
    logic                      room, accept, new_flit, rd_issue, rd_strobe, rd_starts_flit;
    logic [WORD_W-1:0]         rd_word;
    logic                      flit_push, meta_pop, df_pop;

    // Lowest free directory entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < FLUSH_ENTRIES; i++) begin
            if (!dir_vld_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = ID_W'(i);
            end
        end
    end

    // An entry being acked this cycle no longer counts as in flight.
    always_comb begin
        flush_check_hit_o = 1'b0;
        for (int i = 0; i < FLUSH_ENTRIES; i++) begin
            if (dir_vld_q[i] && (dir_nline_q[i] == flush_check_nline_i) &&
                !(mem_resp_write_valid_i && (mem_resp_write_id_i == ID_W'(i))))
                flush_check_hit_o = 1'b1;
        end
    end

    assign flush_empty_o          = ~|dir_vld_q;
    assign flush_full_o           = &dir_vld_q;
    assign flush_ack_o            = mem_resp_write_valid_i;
    assign flush_ack_nline_o      = (mem_resp_write_valid_i && dir_vld_q[mem_resp_write_id_i]) ?
                                    dir_nline_q[mem_resp_write_id_i] : '0;
    assign mem_resp_write_ready_o = 1'b1;

    // A flit is reserved in the data FIFO when its first read issues, so the
    // FIFO can never overflow regardless of how long data_ready stays low.
    assign room                = (FC_W'(FIFO_DEPTH) - df_cnt_q) > inflight_q;
    assign flush_alloc_ready_o = (state_q == ST_IDLE) && !flush_full_o &&
                                 (meta_cnt_q != 2'd2) && room;
    assign accept              = flush_alloc_i && flush_alloc_ready_o;
    assign new_flit            = (word_q & WORD_W'(MEM_WORDS - 1)) == '0;
    assign rd_issue            = (state_q == ST_READ) && (!new_flit || room);
    assign rd_strobe           = accept || rd_issue;
    assign rd_starts_flit      = accept || (rd_issue && new_flit);
    assign rd_word             = accept ? '0 : word_q;

    assign flush_data_read_o      = rd_strobe;
    assign flush_data_read_word_o = rd_strobe ? rd_word : '0;
    assign flush_data_read_set_o  = !rd_strobe ? '0 :
                                    accept ? flush_alloc_nline_i[SET_W-1:0] : set_q;
    assign flush_data_read_way_o  = !rd_strobe ? '0 :
                                    accept ? flush_alloc_way_i : way_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        set_d   = set_q;
        way_d   = way_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    set_d  = flush_alloc_nline_i[SET_W-1:0];
                    way_d  = flush_alloc_way_i;
                    word_d = WORD_W'(ACCESS_WORDS);
                    if (CL_WORDS > ACCESS_WORDS) state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_issue) begin
                    word_d = word_q + WORD_W'(ACCESS_WORDS);
                    if (word_q == LAST_WORD) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response packing: slot acc_q of the flit under construction.
    always_comb begin
        flit_data_n = flit_data_q;
        flit_be_n   = flit_be_q;
        for (int s = 0; s < APF; s++) begin
            if (acc_q == SLOT_W'(s)) begin
                flit_data_n[s*ACC_W +: ACC_W]  = flush_data_read_data_i;
                flit_be_n[s*ACC_BE +: ACC_BE] = flush_data_read_dirty_i;
            end
        end
    end

    assign flit_push = rsp_vld_q && (acc_q == LAST_SLOT);

    always_comb begin
        dir_vld_d = dir_vld_q;
        if (mem_resp_write_valid_i) dir_vld_d[mem_resp_write_id_i] = 1'b0;
        if (accept)                 dir_vld_d[free_idx] = 1'b1;
    end

    assign meta_pop                   = (meta_cnt_q != 2'd0) && mem_req_write_ready_i;
    assign mem_req_write_valid_o      = meta_cnt_q != 2'd0;
    assign mem_req_write_addr_o       = mem_req_write_valid_o ? meta_addr_q[meta_rptr_q] : '0;
    assign mem_req_write_id_o         = mem_req_write_valid_o ? meta_id_q[meta_rptr_q] : '0;
    assign mem_req_write_len_o        = mem_req_write_valid_o ? LEN : '0;

    assign df_pop                     = (df_cnt_q != '0) && mem_req_write_data_ready_i;
    assign mem_req_write_data_valid_o = df_cnt_q != '0;
    assign mem_req_write_data_o       = mem_req_write_data_valid_o ? df_data_q[df_rptr_q] : '0;
    assign mem_req_write_be_o         = mem_req_write_data_valid_o ? df_be_q[df_rptr_q] : '0;
    assign mem_req_write_last_o       = mem_req_write_data_valid_o && df_last_q[df_rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            set_q       <= '0;
            way_q       <= '0;
            dir_vld_q   <= '0;
            for (int i = 0; i < FLUSH_ENTRIES; i++) dir_nline_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                meta_addr_q[i] <= '0;
                meta_id_q[i]   <= '0;
            end
            meta_wptr_q <= 1'b0;
            meta_rptr_q <= 1'b0;
            meta_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                df_data_q[i] <= '0;
                df_be_q[i]   <= '0;
            end
            df_last_q   <= '0;
            df_wptr_q   <= '0;
            df_rptr_q   <= '0;
            df_cnt_q    <= '0;
            inflight_q  <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            acc_q       <= '0;
            flit_data_q <= '0;
            flit_be_q   <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            set_q     <= set_d;
            way_q     <= way_d;
            dir_vld_q <= dir_vld_d;
            if (accept) begin
                dir_nline_q[free_idx]    <= flush_alloc_nline_i;
                meta_addr_q[meta_wptr_q] <= {flush_alloc_nline_i, {OFF_W{1'b0}}};
                meta_id_q[meta_wptr_q]   <= free_idx;
                meta_wptr_q              <= ~meta_wptr_q;
            end
            if (meta_pop) meta_rptr_q <= ~meta_rptr_q;
            meta_cnt_q <= meta_cnt_q + 2'(accept) - 2'(meta_pop);

            // Read data returns one cycle after the strobe.
            rsp_vld_q  <= rd_strobe;
            rsp_last_q <= rd_strobe && (rd_word == LAST_WORD);
            if (rsp_vld_q) begin
                acc_q       <= (acc_q == LAST_SLOT) ? '0 : acc_q + SLOT_W'(1);
                flit_data_q <= flit_data_n;
                flit_be_q   <= flit_be_n;
            end
            if (flit_push) begin
                df_data_q[df_wptr_q] <= flit_data_n;
                df_be_q[df_wptr_q]   <= flit_be_n;
                df_last_q[df_wptr_q] <= rsp_last_q;
                df_wptr_q <= (df_wptr_q == FP_W'(FIFO_DEPTH - 1)) ? '0 : df_wptr_q + FP_W'(1);
            end
            if (df_pop)
                df_rptr_q <= (df_rptr_q == FP_W'(FIFO_DEPTH - 1)) ? '0 : df_rptr_q + FP_W'(1);
            df_cnt_q   <= df_cnt_q + FC_W'(flit_push) - FC_W'(df_pop);
            inflight_q <= inflight_q + FC_W'(rd_starts_flit) - FC_W'(flit_push);
        end
    end

endmodule

// File: tb/tb_hpdcache_flush_be.sv
module tb_hpdcache_flush_be;
    localparam int NLINE_W = 26, SET_W = 7, WAYS = 4, CL_WORDS = 8, ACCESS_WORDS = 2;
    localparam int MEM_WORDS = 4, FE = 4, FIFO_DEPTH = 2, ID_W = 2, WORD_W = 3, ADDR_W = 32;
    localparam int FLITS = CL_WORDS / MEM_WORDS;
    localparam int SETS = 1 << SET_W;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                      flush_empty_o, flush_full_o, flush_check_hit_o, flush_alloc_ready_o;
    logic [NLINE_W-1:0]        flush_check_nline_i = '0, flush_alloc_nline_i = '0, flush_ack_nline_o;
    logic                      flush_alloc_i = 1'b0;
    logic [WAYS-1:0]           flush_alloc_way_i = '0, flush_data_read_way_o;
    logic                      flush_data_read_o, flush_ack_o;
    logic [SET_W-1:0]          flush_data_read_set_o;
    logic [WORD_W-1:0]         flush_data_read_word_o;
    logic [64*ACCESS_WORDS-1:0] flush_data_read_data_i = '0;
    logic [8*ACCESS_WORDS-1:0] flush_data_read_dirty_i = '0;
    logic                      mem_req_write_ready_i = 1'b0, mem_req_write_valid_o;
    logic [ADDR_W-1:0]         mem_req_write_addr_o;
    logic [7:0]                mem_req_write_len_o;
    logic [ID_W-1:0]           mem_req_write_id_o, mem_resp_write_id_i = '0;
    logic                      mem_req_write_data_ready_i = 1'b0, mem_req_write_data_valid_o;
    logic [64*MEM_WORDS-1:0]   mem_req_write_data_o;
    logic [8*MEM_WORDS-1:0]    mem_req_write_be_o;
    logic                      mem_req_write_last_o, mem_resp_write_valid_i = 1'b0, mem_resp_write_ready_o;

    hpdcache_flush_be dut (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_empty_o(flush_empty_o), .flush_full_o(flush_full_o),
        .flush_check_nline_i(flush_check_nline_i), .flush_check_hit_o(flush_check_hit_o),
        .flush_alloc_i(flush_alloc_i), .flush_alloc_ready_o(flush_alloc_ready_o),
        .flush_alloc_nline_i(flush_alloc_nline_i), .flush_alloc_way_i(flush_alloc_way_i),
        .flush_data_read_o(flush_data_read_o), .flush_data_read_set_o(flush_data_read_set_o),
        .flush_data_read_word_o(flush_data_read_word_o), .flush_data_read_way_o(flush_data_read_way_o),
        .flush_data_read_data_i(flush_data_read_data_i), .flush_data_read_dirty_i(flush_data_read_dirty_i),
        .flush_ack_o(flush_ack_o), .flush_ack_nline_o(flush_ack_nline_o),
        .mem_req_write_ready_i(mem_req_write_ready_i), .mem_req_write_valid_o(mem_req_write_valid_o),
        .mem_req_write_addr_o(mem_req_write_addr_o), .mem_req_write_len_o(mem_req_write_len_o),
        .mem_req_write_id_o(mem_req_write_id_o),
        .mem_req_write_data_ready_i(mem_req_write_data_ready_i),
        .mem_req_write_data_valid_o(mem_req_write_data_valid_o),
        .mem_req_write_data_o(mem_req_write_data_o), .mem_req_write_be_o(mem_req_write_be_o),
        .mem_req_write_last_o(mem_req_write_last_o),
        .mem_resp_write_valid_i(mem_resp_write_valid_i), .mem_resp_write_id_i(mem_resp_write_id_i),
        .mem_resp_write_ready_o(mem_resp_write_ready_o)
    );

    int n_chk = 0, n_err = 0;

    task automatic check_val(string tag, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Data-array contents seen by the flush engine.
    logic [63:0] data_arr [SETS*WAYS*CL_WORDS];
    logic [7:0]  dirty_arr[SETS*WAYS*CL_WORDS];

    // Reference model: directory plus expected traffic queues.
    typedef struct packed { logic [SET_W-1:0] set; logic [WORD_W-1:0] word; logic [WAYS-1:0] way; } rd_t;
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [ID_W-1:0] id; } meta_t;
    typedef struct packed { logic [255:0] d; logic [31:0] be; logic last; } flit_t;
    rd_t   exp_rd[$];
    meta_t exp_meta[$];
    flit_t exp_flit[$];
    int    line_id_q[$];
    bit    mvld[FE], mdone[FE], ddone[FE];
    logic [NLINE_W-1:0] mnl[FE];

    logic               alloc_req = 0, ack_req = 0, mready = 1, dready = 1;
    logic [NLINE_W-1:0] a_nl = '0, chk_nl = '0;
    logic [WAYS-1:0]    a_way = '0;
    logic [ID_W-1:0]    ack_id = '0;
    bit                 pend_rd = 0;
    int                 pend_idx = 0, rd_cnt = 0;

    function automatic int aidx(int set, int wi, int word);
        return (set * WAYS + wi) * CL_WORDS + word;
    endfunction

    function automatic int wayidx(logic [WAYS-1:0] w);
        for (int i = 0; i < WAYS; i++) if (w[i]) return i;
        return 0;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < FE; i++) if (mvld[i]) c++;
        return c;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < FE; i++) if (!mvld[i]) return i;
        return -1;
    endfunction

    function automatic int pick_ackable();
        int l[$];
        for (int i = 0; i < FE; i++) if (mvld[i] && mdone[i] && ddone[i]) l.push_back(i);
        if (l.size() == 0) return -1;
        return l[$urandom_range(0, l.size() - 1)];
    endfunction

    function automatic bit busy();
        return (exp_rd.size() != 0) || (exp_meta.size() != 0) || (exp_flit.size() != 0) || alloc_req;
    endfunction

    task automatic clear_model();
        exp_rd.delete(); exp_meta.delete(); exp_flit.delete(); line_id_q.delete();
        for (int i = 0; i < FE; i++) begin mvld[i] = 0; mdone[i] = 0; ddone[i] = 0; end
        pend_rd = 0; alloc_req = 0; ack_req = 0;
    endtask

    task automatic step();
        int id, wi, set;
        bit hit_exp, acc;
        rd_t r; meta_t m; flit_t f;
        @(negedge clk);
        flush_alloc_i = alloc_req; flush_alloc_nline_i = a_nl; flush_alloc_way_i = a_way;
        mem_resp_write_valid_i = ack_req; mem_resp_write_id_i = ack_id;
        flush_check_nline_i = chk_nl;
        mem_req_write_ready_i = mready; mem_req_write_data_ready_i = dready;
        if (pend_rd) begin
            for (int w = 0; w < ACCESS_WORDS; w++) begin
                flush_data_read_data_i[w*64 +: 64] = data_arr[pend_idx + w];
                flush_data_read_dirty_i[w*8 +: 8]  = dirty_arr[pend_idx + w];
            end
        end else begin
            flush_data_read_data_i  = {$urandom, $urandom, $urandom, $urandom};
            flush_data_read_dirty_i = 16'($urandom);
        end
        #1;
        check_val("empty", flush_empty_o, mcount() == 0);
        check_val("full", flush_full_o, mcount() == FE);
        hit_exp = 0;
        for (int i = 0; i < FE; i++)
            if (mvld[i] && mnl[i] == chk_nl && !(ack_req && ack_id == ID_W'(i))) hit_exp = 1;
        check_val("hit", flush_check_hit_o, hit_exp);
        check_val("ack", flush_ack_o, ack_req);
        if (ack_req && mvld[ack_id]) check_val("ack_nline", flush_ack_nline_o, mnl[ack_id]);
        check_val("resp_rdy", mem_resp_write_ready_o, 1);
        if (mcount() == FE) check_val("rdy_full", flush_alloc_ready_o, 0);

        acc = alloc_req && flush_alloc_ready_o;
        id = -1;
        if (acc) begin
            id = lowest_free();
            if (id < 0) begin
                check_val("acc_full", 1, 0);
            end else begin
                set = int'(a_nl[SET_W-1:0]);
                wi  = wayidx(a_way);
                m.addr = {a_nl, 6'd0}; m.id = ID_W'(id);
                exp_meta.push_back(m);
                for (int w = 0; w < CL_WORDS; w += ACCESS_WORDS) begin
                    r.set = a_nl[SET_W-1:0]; r.word = WORD_W'(w); r.way = a_way;
                    exp_rd.push_back(r);
                end
                for (int fl = 0; fl < FLITS; fl++) begin
                    for (int w = 0; w < MEM_WORDS; w++) begin
                        f.d[w*64 +: 64] = data_arr[aidx(set, wi, fl*MEM_WORDS + w)];
                        f.be[w*8 +: 8]  = dirty_arr[aidx(set, wi, fl*MEM_WORDS + w)];
                    end
                    f.last = (fl == FLITS - 1);
                    exp_flit.push_back(f);
                end
                line_id_q.push_back(id);
            end
        end

        if (flush_data_read_o) begin
            rd_cnt++;
            if (exp_rd.size() == 0) check_val("rd_spurious", 1, 0);
            else begin
                r = exp_rd.pop_front();
                check_val("rd_set", flush_data_read_set_o, r.set);
                check_val("rd_word", flush_data_read_word_o, r.word);
                check_val("rd_way", flush_data_read_way_o, r.way);
            end
            pend_rd = 1;
            pend_idx = aidx(int'(flush_data_read_set_o), wayidx(flush_data_read_way_o),
                            int'(flush_data_read_word_o));
        end else pend_rd = 0;

        if (mem_req_write_valid_o && mready) begin
            if (exp_meta.size() == 0) check_val("meta_spurious", 1, 0);
            else begin
                m = exp_meta.pop_front();
                check_val("meta_addr", mem_req_write_addr_o, m.addr);
                check_val("meta_id", mem_req_write_id_o, m.id);
                check_val("meta_len", mem_req_write_len_o, CL_WORDS / MEM_WORDS - 1);
                mdone[m.id] = 1;
            end
        end

        if (mem_req_write_data_valid_o && dready) begin
            if (exp_flit.size() == 0) check_val("flit_spurious", 1, 0);
            else begin
                f = exp_flit.pop_front();
                check_val("flit_data", mem_req_write_data_o, f.d);
                check_val("flit_be", mem_req_write_be_o, f.be);
                check_val("flit_last", mem_req_write_last_o, f.last);
                if (f.last && line_id_q.size() != 0) ddone[line_id_q.pop_front()] = 1;
            end
        end

        if (ack_req) begin mvld[ack_id] = 0; mdone[ack_id] = 0; ddone[ack_id] = 0; end
        if (acc && id >= 0) begin
            mvld[id] = 1; mnl[id] = a_nl; mdone[id] = 0; ddone[id] = 0;
        end
        if (acc) alloc_req = 0;
        ack_req = 0;
    endtask

    task automatic do_alloc(logic [NLINE_W-1:0] nl, logic [WAYS-1:0] w);
        alloc_req = 1; a_nl = nl; a_way = w;
        for (int i = 0; i < 100 && alloc_req; i++) step();
        check_val("alloc_timeout", alloc_req, 0);
        alloc_req = 0;
    endtask

    task automatic drain();
        mready = 1; dready = 1;
        for (int i = 0; i < 300 && busy(); i++) step();
        check_val("drain_timeout", busy(), 0);
    endtask

    task automatic ack_all();
        int id;
        for (int i = 0; i < FE; i++) begin
            id = pick_ackable();
            if (id >= 0) begin ack_req = 1; ack_id = ID_W'(id); step(); end
        end
        step();
    endtask

    task automatic reset_checks();
        check_val("rst_empty", flush_empty_o, 1);
        check_val("rst_full", flush_full_o, 0);
        check_val("rst_dvalid", mem_req_write_data_valid_o, 0);
        check_val("rst_mvalid", mem_req_write_valid_o, 0);
        check_val("rst_read", flush_data_read_o, 0);
        check_val("rst_ack", flush_ack_o, 0);
        check_val("rst_resp_rdy", mem_resp_write_ready_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, id, old;
        for (int i = 0; i < SETS*WAYS*CL_WORDS; i++) begin
            data_arr[i]  = {$urandom, $urandom};
            dirty_arr[i] = 8'($urandom);
        end
        clear_model();
        #12;
        reset_checks();
        check_val("rst_alloc_rdy", flush_alloc_ready_o, 1);
        @(negedge clk); rst_n = 1;

        // Full-dirty line 0x123 in way 1.
        for (int w = 0; w < CL_WORDS; w++) dirty_arr[aidx(7'h23, 1, w)] = 8'hFF;
        do_alloc(26'h123, 4'b0010);
        drain();
        ack_all();

        // Single dirty byte: word 5, byte 0.
        for (int w = 0; w < CL_WORDS; w++) dirty_arr[aidx(7'h56, 3, w)] = 8'h00;
        dirty_arr[aidx(7'h56, 3, 5)] = 8'h01;
        do_alloc(26'h456, 4'b1000);
        drain();
        ack_all();

        // Fill the directory, ack id 2, reallocate.
        for (int k = 0; k < FE; k++) do_alloc(26'h1000 + 26'(k * 7), 4'(1 << k));
        drain();
        alloc_req = 1; a_nl = 26'h2ABC; a_way = 4'b0001;
        repeat (3) step();
        check_val("full_blocked", alloc_req, 1);
        ack_req = 1; ack_id = 2'd2; step();
        for (int i = 0; i < 20 && alloc_req; i++) step();
        check_val("realloc_timeout", alloc_req, 0);
        drain();

        // Check port while acking id 1.
        chk_nl = mnl[1]; ack_req = 1; ack_id = 2'd1; step();
        chk_nl = mnl[0]; step();
        ack_all();

        // Data backpressure.
        mready = 1; dready = 0; r0 = rd_cnt;
        alloc_req = 1; a_nl = 26'h3333; a_way = 4'b0100;
        repeat (5) step();
        alloc_req = 1; a_nl = 26'h3344; a_way = 4'b0010;
        repeat (25) step();
        check_val("stall_reads", rd_cnt - r0, FIFO_DEPTH * MEM_WORDS / ACCESS_WORDS);
        check_val("stall_alloc", alloc_req, 1);
        drain();
        ack_all();

        // Asynchronous reset after the second read of a line.
        old = rd_cnt;
        alloc_req = 1; a_nl = 26'h0BEEF; a_way = 4'b0001;
        for (int i = 0; i < 20 && rd_cnt < old + 2; i++) step();
        check_val("pre_rst_reads", rd_cnt - old, 2);
        @(posedge clk); #2 rst_n = 0; #1;
        reset_checks();
        clear_model();
        @(posedge clk); #1;
        reset_checks();
        @(negedge clk); rst_n = 1;
        do_alloc(26'h0CAFE, 4'b1000);
        drain();
        ack_all();

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            if (!alloc_req && ($urandom % 3 == 0)) begin
                alloc_req = 1; a_nl = 26'($urandom); a_way = 4'(1 << ($urandom % 4));
            end
            id = pick_ackable();
            if (id >= 0 && ($urandom % 3 == 0)) begin ack_req = 1; ack_id = ID_W'(id); end
            else if ($urandom % 12 == 0) begin
                id = lowest_free();
                if (id >= 0) begin ack_req = 1; ack_id = ID_W'(id); end
            end
            if ($urandom % 2 == 0) begin
                int k = $urandom % FE;
                chk_nl = mnl[k];
            end else chk_nl = 26'($urandom);
            mready = ($urandom % 4) != 0;
            dready = ($urandom % 4) != 0;
            step();
        end
        alloc_req = 0;
        drain();
        ack_all();
        ack_all();
        check_val("final_empty", flush_empty_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
